pipe_hazard_ctrl: RTL
=====================

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 Parameter CNT_W, default 16: width of the statistics counters.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 id_valid  input  1  the IF/ID register holds a real instruction.
REQ-005 id_opc  input  6  opcode of the instruction in ID.
REQ-006 id_rs, id_rt, id_rd  input  5 each  register fields of the instruction in ID.
REQ-007 br_taken  input  1  BEQ in MEM resolved taken (Branch AND Zero).
REQ-008 pc_write  output  1  PC update enable.
REQ-009 ifid_write  output  1  IF/ID register update enable.
REQ-010 ifid_flush  output  1  clears IF/ID to a NOP on the next edge.
REQ-011 ctrl_bubble  output  1  forces WB/M/EX control bundles into ID/EX to zero.
REQ-012 exmem_flush  output  1  zeroes WB/M controls entering EX/MEM.
REQ-013 stall_cnt, flush_cnt  output  CNT_W each  event counters (REQ-030).

Function
REQ-014 Block SHALL decode id_opc internally: R=000000, LW=100011, SW=101011, BEQ=000100, ADDI=001000, SLTI=001010, ANDI=001100, ORI=001101, J=000010; other opcodes are NOPs (no register write).
REQ-015 Destination SHALL be id_rd for R-type, id_rt for LW/ADDI/SLTI/ANDI/ORI, none otherwise; destination 0 is never a hazard.
REQ-016 Block SHALL keep an EX-stage shadow (ex_dst, ex_load, ex_wr), loaded from the ID decode on every edge in which ID/EX advances, and cleared to zero when ctrl_bubble or a flush is applied.
REQ-017 Sources: rs for all except J; rt additionally for R-type, SW, BEQ.
REQ-018 FSM states: RUN, LD_STALL, BR_FLUSH; reset state RUN.
REQ-019 RUN: load-use (ex_load AND ex_dst!=0 AND ex_dst matches a used source AND id_valid) SHALL drive pc_write=0, ifid_write=0, ctrl_bubble=1 combinationally and go to LD_STALL.
REQ-020 LD_STALL SHALL last exactly one cycle with all enables 1, no bubble, then return to RUN; total load-use penalty = 1 cycle.
REQ-021 RUN: J in ID with id_valid SHALL assert ifid_flush for one cycle; pc_write stays 1; no state change.
REQ-022 br_taken in any state SHALL assert ifid_flush, ctrl_bubble, exmem_flush in that cycle, override REQ-019/REQ-021, and enter BR_FLUSH.
REQ-023 BR_FLUSH SHALL last one cycle, ignore load-use/J decode from the flushed ID slot, assert no flush outputs, then return to RUN.
REQ-024 br_taken while in BR_FLUSH SHALL restart REQ-022 behaviour (stay in BR_FLUSH).
REQ-025 Simultaneous load-use and J: load-use wins; J is honoured when re-evaluated after LD_STALL.
REQ-026 id_valid=0 SHALL suppress REQ-019 and REQ-021.

Reset
REQ-027 While rst_n=0: state=RUN, shadow cleared, counters 0.
REQ-028 Reset outputs: pc_write=1, ifid_write=1, ifid_flush=0, ctrl_bubble=0, exmem_flush=0.
REQ-029 Reset asserted mid-stall or mid-flush SHALL abort immediately; first post-reset cycle behaves as RUN with empty shadow.

Configuration
REQ-030 Macro HAZARD_STATS_EN defined: stall_cnt +1 per ctrl_bubble cycle caused by load-use, flush_cnt +1 per br_taken or J flush cycle, both saturating at all-ones.
REQ-031 Macro HAZARD_STATS_EN undefined: no counter flops; stall_cnt and flush_cnt tied to 0.

Structure
REQ-032 Opcode constants and FSM state encoding SHALL live in shared package mips_pkg, reused by the control unit.
REQ-033 One sub-module, hz_decode (combinational: destination, sources, is_load, is_jump from opcode/fields), instantiated once.

Verification
REQ-034 LW $t1 in EX, ADD $t2,$t1,$t3 in ID -> one cycle pc_write=0, ifid_write=0, ctrl_bubble=1; next cycle all 1; stall_cnt=1.
REQ-035 LW $0 in EX, ADD using $0 -> no stall.
REQ-036 J in ID -> ifid_flush=1 for exactly one cycle, pc_write=1, flush_cnt=1.
REQ-037 br_taken=1 coincident with load-use -> ifid_flush=ctrl_bubble=exmem_flush=1, pc_write=1, state BR_FLUSH, stall_cnt unchanged.
REQ-038 rst_n low during LD_STALL -> outputs at REQ-028 values asynchronously; after release, RUN, counters 0.
REQ-039 CNT_W=4, 20 load-use stalls with HAZARD_STATS_EN -> stall_cnt=15; without macro -> 0.

Source files
------------

// File: rtl/mips_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : mips_pkg                                                        |
// | Desc     : Shared opcode constants, hazard FSM encoding, decode record.    |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
package mips_pkg;

    localparam logic [5:0] OPC_R    = 6'b000000;
    localparam logic [5:0] OPC_LW   = 6'b100011;
    localparam logic [5:0] OPC_SW   = 6'b101011;
    localparam logic [5:0] OPC_BEQ  = 6'b000100;
    localparam logic [5:0] OPC_ADDI = 6'b001000;
    localparam logic [5:0] OPC_SLTI = 6'b001010;
    localparam logic [5:0] OPC_ANDI = 6'b001100;
    localparam logic [5:0] OPC_ORI  = 6'b001101;
    localparam logic [5:0] OPC_J    = 6'b000010;

    localparam int         ST_W        = 2;
    localparam logic [1:0] ST_RUN      = 2'd0;
    localparam logic [1:0] ST_LD_STALL = 2'd1;
    localparam logic [1:0] ST_BR_FLUSH = 2'd2;

    typedef struct packed {
        logic [4:0] dst;
        logic       wr;
        logic       is_load;
        logic       is_jump;
        logic       use_rs;
        logic       use_rt;
        logic [4:0] src_rs;
        logic [4:0] src_rt;
    } dec_t;

endpackage
`default_nettype wire

// File: rtl/pipe_hazard_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : pipe_hazard_ctrl_if                                             |
// | Desc     : ID-stage view and stall/flush controls of the hazard unit.      |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
interface pipe_hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    logic             id_valid;
    logic [5:0]       id_opc;
    logic [4:0]       id_rs;
    logic [4:0]       id_rt;
    logic [4:0]       id_rd;
    logic             br_taken;
    logic             pc_write;
    logic             ifid_write;
    logic             ifid_flush;
    logic             ctrl_bubble;
    logic             exmem_flush;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    // Pipeline datapath side
    modport master (
        output id_valid, id_opc, id_rs, id_rt, id_rd, br_taken,
        input  pc_write, ifid_write, ifid_flush, ctrl_bubble, exmem_flush,
        input  stall_cnt, flush_cnt
    );

    // Hazard controller side
    modport slave (
        input  id_valid, id_opc, id_rs, id_rt, id_rd, br_taken,
        output pc_write, ifid_write, ifid_flush, ctrl_bubble, exmem_flush,
        output stall_cnt, flush_cnt
    );
endinterface
`default_nettype wire

// File: rtl/hz_decode.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : hz_decode                                                       |
// | Desc     : Combinational ID decode: destination, sources, load/jump flags. |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module hz_decode
    import mips_pkg::*;
(
    input  wire logic [5:0] opc,
    input  wire logic [4:0] rs,
    input  wire logic [4:0] rt,
    input  wire logic [4:0] rd,
    output dec_t            dec
);

    always_comb begin
        dec        = '0;
        dec.src_rs = rs;
        dec.src_rt = rt;
        case (opc)
            OPC_R: begin
                dec.dst    = rd;
                dec.use_rt = 1'b1;
            end
            OPC_LW: begin
                dec.dst     = rt;
                dec.is_load = 1'b1;
            end
            OPC_SW, OPC_BEQ:                      dec.use_rt  = 1'b1;
            OPC_ADDI, OPC_SLTI, OPC_ANDI, OPC_ORI: dec.dst     = rt;
            OPC_J:                                dec.is_jump = 1'b1;
            default: ;
        endcase
        dec.use_rs = !dec.is_jump;
        // $0 is hard-wired, so writing it never creates a dependency
        dec.wr     = (dec.dst != 5'd0);
    end

endmodule
`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : pipe_hazard_ctrl                                                |
// | Desc     : Load-use stall, jump and taken-branch flush control.            |
// |            Macro HAZARD_STATS_EN enables saturating stall/flush counters.  |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module pipe_hazard_ctrl
    import mips_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    pipe_hazard_ctrl_if.slave hz
);

    dec_t            w_dec;
    logic [ST_W-1:0] r_state;
    logic [ST_W-1:0] w_next;
    logic [4:0]      r_ex_dst;
    logic            r_ex_load;
    logic            r_ex_wr;
    logic            w_load_use;
    logic            w_jump;
    logic            w_pc_write;
    logic            w_ifid_write;
    logic            w_ifid_flush;
    logic            w_ctrl_bubble;
    logic            w_exmem_flush;
    logic            w_stall_ev;
    logic            w_flush_ev;
    logic            w_id_live;

    hz_decode u_hz_decode (
        .opc (hz.id_opc),
        .rs  (hz.id_rs),
        .rt  (hz.id_rt),
        .rd  (hz.id_rd),
        .dec (w_dec)
    );

    assign w_load_use = hz.id_valid && r_ex_load && r_ex_wr && (r_ex_dst != 5'd0) &&
                        ((w_dec.use_rs && (w_dec.src_rs == r_ex_dst)) ||
                         (w_dec.use_rt && (w_dec.src_rt == r_ex_dst)));
    assign w_jump     = hz.id_valid && w_dec.is_jump;
    // The slot behind a taken branch is being flushed and must not enter EX
    assign w_id_live  = hz.id_valid && (r_state != ST_BR_FLUSH);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_RUN;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = ST_RUN;
        case (r_state)
            ST_RUN: begin
                if (hz.br_taken)     w_next = ST_BR_FLUSH;
                else if (w_load_use) w_next = ST_LD_STALL;
            end
            ST_LD_STALL, ST_BR_FLUSH: begin
                if (hz.br_taken) w_next = ST_BR_FLUSH;
            end
            default: w_next = ST_RUN;
        endcase
    end

    always_comb begin
        w_pc_write    = 1'b1;
        w_ifid_write  = 1'b1;
        w_ifid_flush  = 1'b0;
        w_ctrl_bubble = 1'b0;
        w_exmem_flush = 1'b0;
        w_stall_ev    = 1'b0;
        w_flush_ev    = 1'b0;
        if (!rst_n) begin
            w_stall_ev = 1'b0;
        end else if (hz.br_taken) begin
            w_ifid_flush  = 1'b1;
            w_ctrl_bubble = 1'b1;
            w_exmem_flush = 1'b1;
            w_flush_ev    = 1'b1;
        end else if (r_state == ST_RUN) begin
            if (w_load_use) begin
                w_pc_write    = 1'b0;
                w_ifid_write  = 1'b0;
                w_ctrl_bubble = 1'b1;
                w_stall_ev    = 1'b1;
            end else if (w_jump) begin
                w_ifid_flush = 1'b1;
                w_flush_ev   = 1'b1;
            end
        end
    end

    assign hz.pc_write    = w_pc_write;
    assign hz.ifid_write  = w_ifid_write;
    assign hz.ifid_flush  = w_ifid_flush;
    assign hz.ctrl_bubble = w_ctrl_bubble;
    assign hz.exmem_flush = w_exmem_flush;

    // EX-stage shadow of the instruction that just left ID
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ex_dst  <= 5'd0;
            r_ex_load <= 1'b0;
            r_ex_wr   <= 1'b0;
        end else if (w_ctrl_bubble || w_ifid_flush || !w_id_live) begin
            r_ex_dst  <= 5'd0;
            r_ex_load <= 1'b0;
            r_ex_wr   <= 1'b0;
        end else begin
            r_ex_dst  <= w_dec.dst;
            r_ex_load <= w_dec.is_load;
            r_ex_wr   <= w_dec.wr;
        end
    end

`ifdef HAZARD_STATS_EN
    localparam logic [CNT_W-1:0] c_one = CNT_W'(1);

    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_stall_ev && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + c_one;
            if (w_flush_ev && (r_flush_cnt != '1)) r_flush_cnt <= r_flush_cnt + c_one;
        end
    end

    assign hz.stall_cnt = r_stall_cnt;
    assign hz.flush_cnt = r_flush_cnt;
`else
    assign hz.stall_cnt = {CNT_W{1'b0}};
    assign hz.flush_cnt = {CNT_W{1'b0}};
`endif

endmodule
`default_nettype wire
